seg_reader: RTL

//  Receive side of the multiplexed 7-segment display bus. Samples the active-low segment
//  and digit-enable lines driven by the display logic and decodes each stable digit back
//  to a hex nibble. Hands assembled frames to a consumer over a valid/ready handshake.

---
 rtl/seg_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg_reader.sv
// seg_reader: decodes the multiplexed 7-segment display bus back into hex frames.
// Define SEG_READER_ERRCNT_EN to add the saturating err_count output.
module seg_reader #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    bad_pattern,
  output logic                    overrun
`ifdef SEG_READER_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    SETTLE,
    CAPTURE,
    DWELL
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   sync1_q;
  logic [SW-1:0]   sync2_q;
  logic [SW-1:0]   prev_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [HW-1:0]   shadow_q;
  logic [HW-1:0]   shadow_d;
  logic [HW-1:0]   hex_q;
  logic [NUM_DIGITS-1:0] filled_q;
  logic [NUM_DIGITS-1:0] filled_c;
  logic [NUM_DIGITS-1:0] filled_d;
  logic [NUM_DIGITS-1:0] sel;
  logic            valid_q;
  logic            bad_q;
  logic            ovr_q;
  logic            same;
  logic            strobe;
  logic            legal;
  logic            blank;
  logic            onehot;
  logic            complete;
  logic            accept;
  logic            bad_d;
  logic            ovr_d;
  logic [3:0]      nib;

  assign hex_out     = hex_q;
  assign valid       = valid_q;
  assign bad_pattern = bad_q;
  assign overrun     = ovr_q;

  assign same = (sync2_q == prev_q);

  always_comb begin
    cnt_d = CW'(1);
    if (same) begin
      if (cnt_q == CW'(STABLE_CYCLES)) cnt_d = cnt_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  // Only a count still settling may strobe; DWELL holds off repeats.
  assign strobe = (state_q == SETTLE) &&
                  (cnt_d == CW'(STABLE_CYCLES));

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (sync2_q[6:0])
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    sel      = ~sync2_q[SW-1:7];
    blank    = (sel == '0);
    onehot   = !blank && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    shadow_d = shadow_q;
    filled_c = filled_q;
    bad_d    = 1'b0;
    if (strobe && !blank) begin
      if (onehot && legal) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            shadow_d[4*i +: 4] = nib;
            filled_c[i]        = 1'b1;
          end
        end
      end else begin
        bad_d    = 1'b1;
        filled_c = '0;
      end
    end
    complete = &filled_c;
    accept   = complete && (!valid_q || ready);
    ovr_d    = complete && !accept;
    filled_d = complete ? '0 : filled_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SETTLE;
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      shadow_q <= '0;
      filled_q <= '0;
      hex_q    <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= {an_n, seg_n};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      filled_q <= filled_d;
      bad_q    <= bad_d;
      ovr_q    <= ovr_d;
      if (accept) begin
        hex_q   <= shadow_d;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        SETTLE:  if (strobe) state_q <= CAPTURE;
        CAPTURE: state_q <= same ? DWELL : SETTLE;
        DWELL:   if (!same) state_q <= SETTLE;
        default: state_q <= SETTLE;
      endcase
    end
  end

`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_q;
  logic [8:0] err_sum;

  assign err_sum   = {1'b0, err_q} + 9'(bad_d) + 9'(ovr_d);
  assign err_count = err_q;

  always_ff @(posedge clk) begin
    if (!reset) err_q <= '0;
    else err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`endif

endmodule
